// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports and one write port.
// Register 0 is hardwired to zero. Reset is asynchronous and clears every register.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    // The extra top bit makes DEPTH == 2**ADDR_W representable in the range compare.
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_en_s;
    logic             rd1_valid_s;
    logic             rd2_valid_s;

    // An address is usable when it is non-zero and inside the implemented depth.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (addr != {ADDR_W{1'b0}}) && ({1'b0, addr} < DEPTH_LIM);
    endfunction

    // Write qualification.
    always_comb begin
        wr_en_s = RegWrite && addr_ok(WriteReg);
    end

    // Next-state for the storage array: hold everything, load at most one entry.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[WriteReg] = WriteData;
        end else begin
            regs_d[WriteReg] = regs_q[WriteReg];
        end
        regs_d[0] = {WIDTH{1'b0}};
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read address qualification.
    always_comb begin
        rd1_valid_s = addr_ok(ReadReg1);
        rd2_valid_s = addr_ok(ReadReg2);
    end

    // Read port 1: no bypass from the write port, stored contents only.
    always_comb begin
        ReadData1 = {WIDTH{1'b0}};
        if (rd1_valid_s) begin
            ReadData1 = regs_q[ReadReg1];
        end else begin
            ReadData1 = {WIDTH{1'b0}};
        end
    end

    // Read port 2.
    always_comb begin
        ReadData2 = {WIDTH{1'b0}};
        if (rd2_valid_s) begin
            ReadData2 = regs_q[ReadReg2];
        end else begin
            ReadData2 = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic
// compared against an array reference model.
module tb_reg_file;

    logic        clk;
    logic        clk_run;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks;
    int failures;
    logic [31:0] model [32];

    reg_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // One write cycle: drive on the falling edge, capture on the rising edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
        @(negedge clk);
        RegWrite  = en;
        WriteReg  = a;
        WriteData = d;
        @(posedge clk);
        #1;
        if (en && a != 5'd0) model[a] = d;
        RegWrite = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        ReadReg1 = a1;
        ReadReg2 = a2;
        #1;
        check({tag, "_p1"}, ReadData1, expect_rd(a1));
        check({tag, "_p2"}, ReadData2, expect_rd(a2));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk_run   = 1'b0;
        reset     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = 5'd0;
        WriteData = 32'd0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        model_clear();

        // 1: reset with no clock, then read every address
        #2 reset = 1'b1;
        #5 reset = 1'b0;
        #2;
        for (int i = 0; i < 32; i++) begin
            rd_check("rst_all", 5'(i), 5'(31 - i));
            check("rst_zero", ReadData1, 32'h0000_0000);
        end
        clk_run = 1'b1;

        // 2: basic writes
        wr(5'd5, 32'hDEAD_BEEF, 1'b1);
        wr(5'd31, 32'h1234_5678, 1'b1);
        rd_check("wr_basic", 5'd5, 5'd31);
        check("wr_r5", ReadData1, 32'hDEAD_BEEF);
        check("wr_r31", ReadData2, 32'h1234_5678);
        rd_check("wr_r6", 5'd6, 5'd6);

        // 3: write to register 0 is discarded
        wr(5'd0, 32'hFFFF_FFFF, 1'b1);
        rd_check("r0", 5'd0, 5'd0);
        check("r0_const", ReadData2, 32'h0000_0000);

        // 4: no bypass -- old value before the edge, new value after
        wr(5'd7, 32'h1111_1111, 1'b1);
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd7;
        WriteData = 32'h2222_2222;
        ReadReg1  = 5'd7;
        ReadReg2  = 5'd7;
        #1;
        check("nobyp_pre1", ReadData1, 32'h1111_1111);
        check("nobyp_pre2", ReadData2, 32'h1111_1111);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        model[7] = 32'h2222_2222;
        check("nobyp_post1", ReadData1, 32'h2222_2222);
        check("nobyp_post2", ReadData2, 32'h2222_2222);

        // 5: RegWrite low holds the register
        wr(5'd9, 32'h0BAD_0009, 1'b1);
        for (int i = 0; i < 4; i++) wr(5'd9, 32'hCAFE_F00D, 1'b0);
        rd_check("we_low", 5'd9, 5'd9);
        check("we_low_val", ReadData1, 32'h0BAD_0009);

        // 6: asynchronous reset overrides an in-flight write
        wr(5'd3, 32'hA5A5_A5A5, 1'b1);
        rd_check("pre_rst", 5'd3, 5'd5);
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd3;
        WriteData = 32'h5A5A_5A5A;
        ReadReg1  = 5'd3;
        ReadReg2  = 5'd31;
        #1 reset = 1'b1;
        #1;
        check("rst_async_r3", ReadData1, 32'h0000_0000);
        check("rst_async_r31", ReadData2, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rst_edge_r3", ReadData1, 32'h0000_0000);
        @(negedge clk);
        reset    = 1'b0;
        RegWrite = 1'b0;
        model_clear();
        rd_check("post_rst", 5'd3, 5'd7);
        wr(5'd3, 32'h5A5A_5A5A, 1'b1);
        rd_check("post_rst_wr", 5'd3, 5'd3);
        check("post_rst_val", ReadData1, 32'h5A5A_5A5A);

        // Random traffic against the model, checking reads before and after each edge
        for (int n = 0; n < 400; n++) begin
            logic        en;
            logic [4:0]  wa, r1, r2;
            logic [31:0] wd;
            en = 1'($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            @(negedge clk);
            RegWrite  = en;
            WriteReg  = wa;
            WriteData = wd;
            ReadReg1  = r1;
            ReadReg2  = r2;
            #1;
            check("rnd_pre1", ReadData1, expect_rd(r1));
            check("rnd_pre2", ReadData2, expect_rd(r2));
            @(posedge clk);
            #1;
            if (en && wa != 5'd0) model[wa] = wd;
            check("rnd_post1", ReadData1, expect_rd(r1));
            check("rnd_post2", ReadData2, expect_rd(r2));
        end
        RegWrite = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
